// File: rtl/vec_axpy_gf256.sv
// Streams S bytes into packed words and writes vec ^ S or vec ^ alpha*S, lane-wise over GF(2^8).
// Optional macro VEC_AXPY_PIPE_EN adds one register stage on the result write port.
module vec_axpy_gf256 #(
  parameter string       PARAMETER_SET = "L1",
  parameter int unsigned MAX_LEN_BYTES = (PARAMETER_SET == "L3") ? 159 :
                                         (PARAMETER_SET == "L5") ? 202 : 104,
  parameter int unsigned N_GF          = 8,
  parameter int unsigned PROC_SIZE     = N_GF * 8,
  parameter int unsigned S_ADDR_W      = 9,
  parameter int unsigned VEC_ADDR_W    = $clog2((MAX_LEN_BYTES + N_GF - 1) / N_GF),
  parameter int unsigned LEN_W         = $clog2(MAX_LEN_BYTES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [7:0]            i_alpha,
  input  logic [S_ADDR_W-1:0]   i_s_start,
  input  logic [LEN_W-1:0]      i_len,
  output logic                  o_s_rd,
  output logic [S_ADDR_W-1:0]   o_s_addr,
  input  logic [7:0]            i_s,
  output logic                  o_vec_rd,
  output logic [VEC_ADDR_W-1:0] o_vec_addr,
  input  logic [PROC_SIZE-1:0]  i_vec,
  output logic                  o_res_wr_en,
  output logic [VEC_ADDR_W-1:0] o_res_addr,
  output logic [PROC_SIZE-1:0]  o_res,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned LANE_W = (N_GF > 1) ? $clog2(N_GF) : 1;
  localparam int unsigned CNT_W  = $clog2(N_GF + 1);
  localparam int unsigned SH_W   = $clog2(PROC_SIZE + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [7:0]              alpha_q, alpha_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [VEC_ADDR_W-1:0]   word_q, word_d;
  logic                    s_rd_q, s_rd_d;
  logic [S_ADDR_W-1:0]     s_addr_q, s_addr_d;
  logic                    s_vld_q, s_vld_d;
  logic                    s_first_q, s_first_d;
  logic                    vec_rd_q, vec_rd_d;
  logic [VEC_ADDR_W-1:0]   vec_addr_q, vec_addr_d;
  logic                    vec_last_q, vec_last_d;
  logic [PROC_SIZE-1:0]    pack_q, pack_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [VEC_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                    wr_last_q, wr_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    final_wr_c;
  logic [PROC_SIZE-1:0]    res_c;

  // GF(2^8) multiply by xtime chain, reduction polynomial 0x11B
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Next-state: read issue, vector read scheduling, byte packing
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    alpha_d    = alpha_q;
    rem_d      = rem_q;
    lane_d     = lane_q;
    word_d     = word_q;
    s_rd_d     = 1'b0;
    s_addr_d   = s_addr_q;
    s_vld_d    = 1'b0;
    s_first_d  = 1'b0;
    vec_rd_d   = 1'b0;
    vec_addr_d = vec_addr_q;
    vec_last_d = 1'b0;
    pack_d     = pack_q;
    cnt_d      = cnt_q;
    wr_d       = vec_rd_q;
    wr_addr_d  = vec_addr_q;
    wr_last_d  = vec_last_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          mode_d  = i_mode;
          alpha_d = i_alpha;
          if (i_len != '0) begin
            state_d  = FETCH;
            s_rd_d   = 1'b1;
            s_addr_d = i_s_start;
            rem_d    = i_len;
            lane_d   = '0;
            word_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        s_vld_d    = 1'b1;
        s_first_d  = (lane_q == '0);
        vec_last_d = (rem_q == LEN_W'(1));
        if ((lane_q == LANE_W'(N_GF - 1)) || (rem_q == LEN_W'(1))) begin
          vec_rd_d   = 1'b1;
          vec_addr_d = word_q;
          word_d     = word_q + VEC_ADDR_W'(1);
        end
        lane_d = (lane_q == LANE_W'(N_GF - 1)) ? '0 : lane_q + LANE_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = DRAIN;
        end else begin
          s_rd_d   = 1'b1;
          s_addr_d = s_addr_q + S_ADDR_W'(1);
          rem_d    = rem_q - LEN_W'(1);
        end
      end
      DRAIN: begin
        if (final_wr_c) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // First byte of a word reloads the pack register; the write of the previous word already sampled it
    if (s_vld_q) begin
      if (s_first_q) begin
        pack_d = PROC_SIZE'(i_s);
        cnt_d  = CNT_W'(1);
      end else begin
        pack_d = {pack_q[PROC_SIZE-9:0], i_s};
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end

    busy_d = (state_d == FETCH) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // Result datapath: left-align partial words, then scale and add per lane
  always_comb begin
    logic [SH_W-1:0]      shamt;
    logic [PROC_SIZE-1:0] aligned;
    logic [7:0]           lane_v;
    shamt   = SH_W'(8 * (N_GF - 32'(cnt_q)));
    aligned = pack_q << shamt;
    res_c   = '0;
    for (int i = 0; i < int'(N_GF); i++) begin
      lane_v = aligned[8*i +: 8];
      if (mode_q) lane_v = gf_mul(alpha_q, lane_v);
      res_c[8*i +: 8] = i_vec[8*i +: 8] ^ lane_v;
    end
    if (!wr_q) res_c = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      alpha_q    <= '0;
      rem_q      <= '0;
      lane_q     <= '0;
      word_q     <= '0;
      s_rd_q     <= 1'b0;
      s_addr_q   <= '0;
      s_vld_q    <= 1'b0;
      s_first_q  <= 1'b0;
      vec_rd_q   <= 1'b0;
      vec_addr_q <= '0;
      vec_last_q <= 1'b0;
      pack_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      alpha_q    <= alpha_d;
      rem_q      <= rem_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      s_rd_q     <= s_rd_d;
      s_addr_q   <= s_addr_d;
      s_vld_q    <= s_vld_d;
      s_first_q  <= s_first_d;
      vec_rd_q   <= vec_rd_d;
      vec_addr_q <= vec_addr_d;
      vec_last_q <= vec_last_d;
      pack_q     <= pack_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      wr_addr_q  <= wr_addr_d;
      wr_last_q  <= wr_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef VEC_AXPY_PIPE_EN
  logic                  wr2_q, wr2_d;
  logic [VEC_ADDR_W-1:0] wr2_addr_q, wr2_addr_d;
  logic                  wr2_last_q, wr2_last_d;
  logic [PROC_SIZE-1:0]  res2_q, res2_d;

  always_comb begin
    wr2_d      = wr_q;
    wr2_addr_d = wr_addr_q;
    wr2_last_d = wr_last_q;
    res2_d     = res_c;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr2_q      <= 1'b0;
      wr2_addr_q <= '0;
      wr2_last_q <= 1'b0;
      res2_q     <= '0;
    end else begin
      wr2_q      <= wr2_d;
      wr2_addr_q <= wr2_addr_d;
      wr2_last_q <= wr2_last_d;
      res2_q     <= res2_d;
    end
  end

  assign final_wr_c  = wr2_q && wr2_last_q;
  assign o_res_wr_en = wr2_q;
  assign o_res_addr  = wr2_addr_q;
  assign o_res       = res2_q;
`else
  assign final_wr_c  = wr_q && wr_last_q;
  assign o_res_wr_en = wr_q;
  assign o_res_addr  = wr_addr_q;
  assign o_res       = res_c;
`endif

  assign o_s_rd     = s_rd_q;
  assign o_s_addr   = s_addr_q;
  assign o_vec_rd   = vec_rd_q;
  assign o_vec_addr = vec_addr_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_vec_axpy_gf256.sv
// Bench for vec_axpy_gf256: vector table, randomized runs against a reference model, reset and held-start sequences.
module tb_vec_axpy_gf256;

  localparam int N   = 8;
  localparam int SAW = 9;
  localparam int VAW = 4;
  localparam int LW  = 7;
  localparam int PS  = 64;
`ifdef VEC_AXPY_PIPE_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_start = 1'b0;
  logic           i_mode = 1'b0;
  logic [7:0]     i_alpha = '0;
  logic [SAW-1:0] i_s_start = '0;
  logic [LW-1:0]  i_len = '0;
  logic           o_s_rd;
  logic [SAW-1:0] o_s_addr;
  logic [7:0]     i_s = '0;
  logic           o_vec_rd;
  logic [VAW-1:0] o_vec_addr;
  logic [PS-1:0]  i_vec = '0;
  logic           o_res_wr_en;
  logic [VAW-1:0] o_res_addr;
  logic [PS-1:0]  o_res;
  logic           o_busy;
  logic           o_done;

  vec_axpy_gf256 dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_mode(i_mode), .i_alpha(i_alpha),
    .i_s_start(i_s_start), .i_len(i_len), .o_s_rd(o_s_rd), .o_s_addr(o_s_addr), .i_s(i_s),
    .o_vec_rd(o_vec_rd), .o_vec_addr(o_vec_addr), .i_vec(i_vec), .o_res_wr_en(o_res_wr_en),
    .o_res_addr(o_res_addr), .o_res(o_res), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]    s_mem [512];
  logic [PS-1:0] vec_mem [16];

  // Memories with one-cycle read latency
  always @(posedge clk) begin
    if (o_s_rd) i_s <= s_mem[o_s_addr];
    if (o_vec_rd) i_vec <= vec_mem[o_vec_addr];
  end

  typedef struct {int c; logic [63:0] a; logic [63:0] d;} ev_t;
  ev_t sr_q[$];
  ev_t vr_q[$];
  ev_t wr_q[$];
  int  done_c[$];
  int  busy_n = 0;

  function automatic ev_t mk(input int c, input logic [63:0] a, input logic [63:0] d);
    ev_t e;
    e.c = c; e.a = a; e.d = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (o_s_rd) sr_q.push_back(mk(cyc, 64'(o_s_addr), 64'h0));
    if (o_vec_rd) vr_q.push_back(mk(cyc, 64'(o_vec_addr), 64'h0));
    if (o_res_wr_en) wr_q.push_back(mk(cyc, 64'(o_res_addr), o_res));
    if (o_done) done_c.push_back(cyc);
    if (o_busy) busy_n++;
  end

  task automatic clear_logs();
    sr_q.delete(); vr_q.delete(); wr_q.delete(); done_c.delete(); busy_n = 0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Carry-less product followed by polynomial long division by 0x11B
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
    int prod = 0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (int'(a) << i);
    for (int bt = 14; bt >= 8; bt--) if (((prod >> bt) & 1) != 0) prod = prod ^ (32'h11B << (bt - 8));
    return 8'(prod);
  endfunction

  function automatic logic [63:0] exp_word(input int w, input logic m, input logic [7:0] a,
                                          input int ss, input int len);
    logic [63:0] r;
    logic [7:0]  b;
    r = vec_mem[w];
    for (int j = 0; j < N; j++) begin
      if (w * N + j < len) begin
        b = s_mem[(ss + w * N + j) % 512];
        if (m) b = gf_ref(a, b);
        r[8*(N-1-j) +: 8] = r[8*(N-1-j) +: 8] ^ b;
      end
    end
    return r;
  endfunction

  task automatic start_op(input logic m, input logic [7:0] a, input int ss, input int len, output int t0);
    clear_logs();
    @(negedge clk);
    i_mode = m; i_alpha = a; i_s_start = SAW'(ss); i_len = LW'(len); i_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic verify(input string tg, input logic m, input logic [7:0] a, input int ss,
                        input int len, input int t0);
    int nw, kw;
    nw = (len + N - 1) / N;
    chk({tg, " s_rd count"}, 64'(sr_q.size()), 64'(len));
    for (int k = 0; k < sr_q.size() && k < len; k++) begin
      chk($sformatf("%s s_addr[%0d]", tg, k), sr_q[k].a, 64'((ss + k) % 512));
      chk($sformatf("%s s_rd cyc[%0d]", tg, k), 64'(sr_q[k].c), 64'(t0 + 1 + k));
    end
    chk({tg, " vec_rd count"}, 64'(vr_q.size()), 64'(nw));
    chk({tg, " write count"}, 64'(wr_q.size()), 64'(nw));
    for (int w = 0; w < nw; w++) begin
      kw = ((w + 1) * N < len ? (w + 1) * N : len) - 1;
      if (w < vr_q.size()) begin
        chk($sformatf("%s vec_addr[%0d]", tg, w), vr_q[w].a, 64'(w));
        chk($sformatf("%s vec_rd cyc[%0d]", tg, w), 64'(vr_q[w].c), 64'(t0 + 2 + kw));
      end
      if (w < wr_q.size()) begin
        chk($sformatf("%s res_addr[%0d]", tg, w), wr_q[w].a, 64'(w));
        chk($sformatf("%s res cyc[%0d]", tg, w), 64'(wr_q[w].c), 64'(t0 + 3 + kw + P));
        chk($sformatf("%s res data[%0d]", tg, w), wr_q[w].d, exp_word(w, m, a, ss, len));
      end
    end
    chk({tg, " done count"}, 64'(done_c.size()), 64'd1);
    if (done_c.size() > 0)
      chk({tg, " done cyc"}, 64'(done_c[0]), 64'(len == 0 ? t0 + 1 : t0 + 3 + len + P));
    chk({tg, " busy cycles"}, 64'(busy_n), 64'(len == 0 ? 0 : len + 2 + P));
  endtask

  task automatic fill(input bit ramp, input logic [7:0] sv, input logic [63:0] vv,
                      input int ss, input int len);
    for (int i = 0; i < 512; i++) s_mem[i] = 8'($urandom);
    for (int k = 0; k < len; k++) s_mem[(ss + k) % 512] = ramp ? 8'(k) : sv;
    for (int w = 0; w < 16; w++) vec_mem[w] = vv;
  endtask

  typedef struct {
    logic mode; logic [7:0] alpha; int ss; int len; bit ramp; logic [7:0] sv;
    logic [63:0] vv; logic [63:0] exp_w0; logic [63:0] exp_wl; int exp_nw;
  } vec_t;

  function automatic logic [63:0] out_vec();
    return 64'({o_s_rd, o_s_addr, o_vec_rd, o_vec_addr, o_res_wr_en, o_res_addr, o_busy, o_done}) | o_res;
  endfunction

  initial begin
    vec_t tab[7];
    int   t0, dc, m, len, ss;
    logic [7:0] a;

    tab[0] = '{1'b0, 8'h00, 126, 104, 1'b1, 8'h00, 64'h0,
               64'h0001020304050607, 64'h6061626364656667, 13};
    tab[1] = '{1'b0, 8'h00, 0, 100, 1'b0, 8'hFF, 64'h1111111111111111,
               64'hEEEEEEEEEEEEEEEE, 64'hEEEEEEEE11111111, 13};
    tab[2] = '{1'b1, 8'h02, 40, 16, 1'b0, 8'h80, 64'h0,
               64'h1B1B1B1B1B1B1B1B, 64'h1B1B1B1B1B1B1B1B, 2};
    tab[3] = '{1'b1, 8'h00, 40, 16, 1'b0, 8'h80, 64'h0123456789ABCDEF,
               64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 2};
    tab[4] = '{1'b1, 8'h53, 7, 8, 1'b0, 8'hCA, 64'h0,
               64'h0101010101010101, 64'h0101010101010101, 1};
    tab[5] = '{1'b0, 8'h00, 300, 1, 1'b0, 8'hAB, 64'h0,
               64'hAB00000000000000, 64'hAB00000000000000, 1};
    tab[6] = '{1'b0, 8'h00, 510, 9, 1'b1, 8'h00, 64'h0,
               64'h0001020304050607, 64'h0800000000000000, 2};

    for (int i = 0; i < 16; i++) vec_mem[i] = '0;
    for (int i = 0; i < 512; i++) s_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset outputs", out_vec(), 64'h0);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      fill(tab[i].ramp, tab[i].sv, tab[i].vv, tab[i].ss, tab[i].len);
      start_op(tab[i].mode, tab[i].alpha, tab[i].ss, tab[i].len, t0);
      repeat (tab[i].len + 12) @(negedge clk);
      chk($sformatf("tab%0d nwrites", i), 64'(wr_q.size()), 64'(tab[i].exp_nw));
      if (wr_q.size() > 0) begin
        chk($sformatf("tab%0d word0", i), wr_q[0].d, tab[i].exp_w0);
        chk($sformatf("tab%0d wordlast", i), wr_q[wr_q.size()-1].d, tab[i].exp_wl);
      end
      verify($sformatf("tab%0d", i), tab[i].mode, tab[i].alpha, tab[i].ss, tab[i].len, t0);
    end

    // Zero-length start
    start_op(1'b0, 8'h00, 5, 0, t0);
    repeat (10) @(negedge clk);
    verify("len0", 1'b0, 8'h00, 5, 0, t0);

    // Randomized runs against the reference model
    for (int r = 0; r < 24; r++) begin
      m   = int'($urandom_range(0, 1));
      a   = 8'($urandom);
      ss  = int'($urandom_range(0, 511));
      len = (r < 2) ? 104 - r : int'($urandom_range(0, 104));
      for (int i = 0; i < 512; i++) s_mem[i] = 8'($urandom);
      for (int w = 0; w < 16; w++) vec_mem[w] = {32'($urandom), 32'($urandom)};
      start_op(1'(m), a, ss, len, t0);
      repeat (len + 12) @(negedge clk);
      verify($sformatf("rnd%0d", r), 1'(m), a, ss, len, t0);
    end

    // Reset in the middle of a run, then a fresh run
    fill(1'b1, 8'h00, 64'h5555AAAA5555AAAA, 3, 104);
    start_op(1'b1, 8'h07, 3, 104, t0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort outputs", out_vec(), 64'h0);
    rst = 1'b0;
    clear_logs();
    repeat (130) @(negedge clk);
    chk("abort done count", 64'(done_c.size()), 64'd0);
    chk("abort write count", 64'(wr_q.size()), 64'd0);
    chk("abort s_rd count", 64'(sr_q.size()), 64'd0);
    start_op(1'b1, 8'h07, 3, 104, t0);
    repeat (116) @(negedge clk);
    verify("post_abort", 1'b1, 8'h07, 3, 104, t0);

    // i_start held high across a whole run
    fill(1'b1, 8'h00, 64'h0, 20, 10);
    clear_logs();
    @(negedge clk);
    i_mode = 1'b0; i_alpha = 8'h00; i_s_start = SAW'(20); i_len = LW'(10); i_start = 1'b1;
    t0 = cyc;
    dc = t0 + 13 + P;
    repeat (dc + 2 - t0) @(negedge clk);
    i_start = 1'b0;
    repeat (40) @(negedge clk);
    chk("held done count", 64'(done_c.size()), 64'd2);
    if (done_c.size() > 0) chk("held done0 cyc", 64'(done_c[0]), 64'(dc));
    chk("held s_rd count", 64'(sr_q.size()), 64'd20);
    if (sr_q.size() > 10) chk("held rerun s_rd cyc", 64'(sr_q[10].c), 64'(dc + 2));
    chk("held write count", 64'(wr_q.size()), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
